// File: rtl/mul_div_sequencer.sv
// Iterative radix-2 multiply/divide sequencer for the MIPS Execute stage.
// Runs shift-add multiply or restoring divide over DATASIZE cycles, then writes HI/LO.
module mul_div_sequencer #(
    parameter int DATASIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Start_E,
    input  logic [1:0]          Op_E,
    input  logic [DATASIZE-1:0] SrcA_E,
    input  logic [DATASIZE-1:0] SrcB_E,
    input  logic                HiLoUse_D,
    output logic [DATASIZE-1:0] Hi,
    output logic [DATASIZE-1:0] Lo,
    output logic                Busy,
    output logic                Done,
    output logic                Mdu_Stall
);
    localparam int CW = $clog2(DATASIZE);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    is_div;
    logic                    neg_q;
    logic                    neg_r;
    logic                    div_zero;
    logic [DATASIZE-1:0]     b_mag;
    logic [DATASIZE-1:0]     quo;
    logic [DATASIZE-1:0]     rem;
    logic [2*DATASIZE-1:0]   acc;

    logic                    sign_a;
    logic                    sign_b;
    logic [DATASIZE-1:0]     a_mag_in;
    logic [DATASIZE-1:0]     b_mag_in;
    logic [DATASIZE:0]       mul_sum;
    logic [DATASIZE:0]       div_shift;
    logic [DATASIZE-1:0]     div_diff;
    logic                    div_ge;

    function automatic logic [DATASIZE-1:0] cond_neg(input logic [DATASIZE-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*DATASIZE-1:0] cond_neg2(input logic [2*DATASIZE-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Op_E[0]=0 selects the signed variants
    assign sign_a   = ~Op_E[0] & SrcA_E[DATASIZE-1];
    assign sign_b   = ~Op_E[0] & SrcB_E[DATASIZE-1];
    assign a_mag_in = cond_neg(SrcA_E, sign_a);
    assign b_mag_in = cond_neg(SrcB_E, sign_b);

    assign mul_sum   = {1'b0, acc[2*DATASIZE-1:DATASIZE]} + {1'b0, (acc[0] ? b_mag : '0)};

    // Trial remainder is DATASIZE+1 bits; a successful subtract always fits back in DATASIZE
    assign div_shift = {rem, quo[DATASIZE-1]};
    assign div_ge    = div_shift >= {1'b0, b_mag};
    assign div_diff  = div_shift[DATASIZE-1:0] - b_mag;

    assign Mdu_Stall = HiLoUse_D & (Busy | Start_E);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Hi    <= '0;
            Lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start_E) begin
                        state    <= CALC;
                        Busy     <= 1'b1;
                        cnt      <= CW'(DATASIZE - 1);
                        is_div   <= Op_E[1];
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= Op_E[1] & (SrcB_E == '0);
                        b_mag    <= b_mag_in;
                        quo      <= a_mag_in;
                        rem      <= '0;
                        acc      <= {{DATASIZE{1'b0}}, a_mag_in};
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem <= div_ge ? div_diff : div_shift[DATASIZE-1:0];
                        quo <= {quo[DATASIZE-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[DATASIZE-1:1]};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= SIGN;
                        Done  <= 1'b1;
                    end
                end
                SIGN: begin
                    if (is_div) begin
                        Lo <= div_zero ? '1 : cond_neg(quo, neg_q);
                        Hi <= cond_neg(rem, neg_r);
                    end else begin
                        {Hi, Lo} <= cond_neg2(acc, neg_q);
                    end
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer: directed corner cases plus randomized ops
// compared against a plain-arithmetic model of MULT/MULTU/DIV/DIVU.
module tb_mul_div_sequencer;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start_E;
    logic [1:0]  Op_E;
    logic [31:0] SrcA_E;
    logic [31:0] SrcB_E;
    logic        HiLoUse_D;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;
    logic        Mdu_Stall;

    int total = 0;
    int bad   = 0;
    logic allow_inject = 1'b0;

    mul_div_sequencer #(.DATASIZE(32)) dut (
        .clk(clk), .rst(rst), .Start_E(Start_E), .Op_E(Op_E),
        .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .HiLoUse_D(HiLoUse_D),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .Mdu_Stall(Mdu_Stall)
    );

    always #5 clk = ~clk;

    // Correct stalling must never let a new op reach a busy sequencer
    always @(posedge clk) begin
        if (!rst && Start_E && Busy && !allow_inject) begin
            bad++;
            $display("FAIL start_while_busy: got Start_E=1 Busy=1 want no overlap");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb;
        logic [63:0] p;
        int ia, ib;
        p  = '0;
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT: begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
                {hi, lo} = p;
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                {hi, lo} = p;
            end
            OP_DIV: begin
                ia = a;
                ib = b;
                if (b == 32'd0) begin
                    lo = 32'hFFFFFFFF; hi = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    lo = 32'h80000000; hi = 32'd0;
                end else begin
                    lo = ia / ib; hi = ia % ib;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFFFFFF; hi = a;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    // Issues one op, returns the cycle (1 = cycle after the accepting edge) in which Done was seen
    // and Hi/Lo sampled just after the following edge.
    task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int done_cyc, output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        Start_E = 1'b1; Op_E = op; SrcA_E = a; SrcB_E = b;
        @(posedge clk); #1;
        Start_E = 1'b0;
        done_cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (Done) begin
                done_cyc = k;
                break;
            end
        end
        @(posedge clk); #1;
        hi = Hi;
        lo = Lo;
    endtask

    task automatic test_reset();
        rst = 1'b1; Start_E = 1'b0; Op_E = 2'b00; SrcA_E = '0; SrcB_E = '0; HiLoUse_D = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (Hi !== 32'd0)  begin bad++; $display("FAIL reset_hi: got %h want 0", Hi); end
        total++; if (Lo !== 32'd0)  begin bad++; $display("FAIL reset_lo: got %h want 0", Lo); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", Done); end
        rst = 1'b0;
        #1;
        total++; if (Mdu_Stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", Mdu_Stall); end
    endtask

    task automatic test_multu_max();
        int dc; logic [31:0] hi, lo;
        issue_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, dc, hi, lo);
        total++; if (dc != LAT) begin bad++; $display("FAIL multu_latency: got %0d want %0d", dc, LAT); end
        total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL multu_busy_after: got %b want 0", Busy); end
    endtask

    task automatic test_mult_signed();
        int dc; logic [31:0] hi, lo;
        issue_op(OP_MULT, 32'hFFFFFFFD, 32'd7, dc, hi, lo);
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
    endtask

    task automatic test_divide();
        int dc; logic [31:0] hi, lo;
        issue_op(OP_DIV, 32'hFFFFFFF9, 32'd2, dc, hi, lo);
        total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
        issue_op(OP_DIVU, 32'd100, 32'd7, dc, hi, lo);
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        total++; if (hi !== 32'd2)  begin bad++; $display("FAIL divu_hi: got %h want 00000002", hi); end
        total++; if (dc != LAT) begin bad++; $display("FAIL divu_latency: got %0d want %0d", dc, LAT); end
    endtask

    task automatic test_div_corner();
        int dc; logic [31:0] hi, lo;
        issue_op(OP_DIVU, 32'h1234, 32'd0, dc, hi, lo);
        total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divzero_lo: got %h want ffffffff", lo); end
        total++; if (hi !== 32'h1234)     begin bad++; $display("FAIL divzero_hi: got %h want 00001234", hi); end
        total++; if (dc != LAT) begin bad++; $display("FAIL divzero_latency: got %0d want %0d", dc, LAT); end
        issue_op(OP_DIV, 32'hFFFFFF00, 32'd0, dc, hi, lo);
        total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL sdivzero_lo: got %h want ffffffff", lo); end
        total++; if (hi !== 32'hFFFFFF00) begin bad++; $display("FAIL sdivzero_hi: got %h want ffffff00", hi); end
        issue_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, dc, hi, lo);
        total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
        total++; if (hi !== 32'd0)        begin bad++; $display("FAIL divovf_hi: got %h want 0", hi); end
    endtask

    task automatic test_stall_inject();
        logic stall_ok; int done_at; logic [31:0] eh, el, hi0, lo0;
        logic lohi_stable;
        ref_model(OP_MULT, 32'hFFFFFFFB, 32'd9, eh, el);
        @(negedge clk);
        hi0 = Hi; lo0 = Lo;
        Start_E = 1'b1; Op_E = OP_MULT; SrcA_E = 32'hFFFFFFFB; SrcB_E = 32'd9; HiLoUse_D = 1'b1;
        #1;
        total++; if (Mdu_Stall !== 1'b1) begin bad++; $display("FAIL stall_issue: got %b want 1", Mdu_Stall); end
        @(posedge clk); #1;
        Start_E = 1'b0;
        stall_ok = 1'b1; done_at = -1; lohi_stable = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 10) begin
                allow_inject = 1'b1;
                Start_E = 1'b1; Op_E = OP_DIVU; SrcA_E = 32'd100; SrcB_E = 32'd3;
            end else if (k == 11) begin
                Start_E = 1'b0; allow_inject = 1'b0;
            end
            if (Mdu_Stall !== 1'b1) stall_ok = 1'b0;
            if (Hi !== hi0 || Lo !== lo0) lohi_stable = 1'b0;
            if (Done === 1'b1 && done_at < 0) done_at = k;
        end
        total++; if (stall_ok !== 1'b1) begin bad++; $display("FAIL stall_busy: got low stall want high through done"); end
        total++; if (lohi_stable !== 1'b1) begin bad++; $display("FAIL hilo_stable: got change want hold until done edge"); end
        total++; if (done_at != LAT) begin bad++; $display("FAIL stall_done_cycle: got %0d want %0d", done_at, LAT); end
        @(negedge clk);
        total++; if (Mdu_Stall !== 1'b0) begin bad++; $display("FAIL stall_release: got %b want 0", Mdu_Stall); end
        total++; if (Hi !== eh || Lo !== el) begin
            bad++; $display("FAIL inject_result: got %h_%h want %h_%h", Hi, Lo, eh, el);
        end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL inject_busy: got %b want 0", Busy); end
        HiLoUse_D = 1'b0;
    endtask

    task automatic test_reset_abort();
        int dc; logic [31:0] hi, lo; logic saw_done;
        @(negedge clk);
        Start_E = 1'b1; Op_E = OP_DIV; SrcA_E = 32'hFFFFFC18; SrcB_E = 32'd7;
        @(posedge clk); #1;
        Start_E = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", Busy); end
        total++; if (Hi !== 32'd0)  begin bad++; $display("FAIL abort_hi: got %h want 0", Hi); end
        total++; if (Lo !== 32'd0)  begin bad++; $display("FAIL abort_lo: got %h want 0", Lo); end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (Done !== 1'b0) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done: got pulse want none"); end
        issue_op(OP_MULTU, 32'd6, 32'd7, dc, hi, lo);
        total++; if (lo !== 32'd42) begin bad++; $display("FAIL post_abort_lo: got %h want 0000002a", lo); end
        total++; if (hi !== 32'd0)  begin bad++; $display("FAIL post_abort_hi: got %h want 0", hi); end
    endtask

    task automatic test_random();
        int dc; logic [31:0] hi, lo, eh, el, a, b; logic [1:0] op;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            ref_model(op, a, b, eh, el);
            issue_op(op, a, b, dc, hi, lo);
            total++; if (hi !== eh) begin bad++; $display("FAIL rand_hi[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, hi, eh); end
            total++; if (lo !== el) begin bad++; $display("FAIL rand_lo[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, lo, el); end
            total++; if (dc != LAT) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, dc, LAT); end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_divide();
        test_div_corner();
        test_stall_inject();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
